// File: rtl/keypad_pkg.sv
// Shared key codes, debounce state encoding and the row/column to key-code map.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } kp_state_e;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    if (row == 2'd3) begin
      case (col)
        2'd0:    return KEY_STAR;
        2'd1:    return KEY_0;
        default: return KEY_HASH;
      endcase
    end
    return ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Frame-rate press/release debouncer producing the key_valid/key_value stream.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_frame_end,
  input  logic [3:0] i_frame_code,
  output logic       o_key_valid,
  output logic [3:0] o_key_value,
  output logic       o_key_busy
);

  localparam logic [15:0] DEB = 16'(DEBOUNCE_FRAMES);

  if (DEBOUNCE_FRAMES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("keypad_debounce_fsm: frame counts must be at least 1");
  end

  kp_state_e   r_state;
  logic [3:0]  r_cand;
  logic [15:0] r_cnt;
  logic        r_valid;
  logic [3:0]  r_value;
  logic        r_busy;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] RDLY = 16'(REPEAT_DELAY);
  localparam logic [15:0] RPER = 16'(REPEAT_PERIOD);
  logic [15:0] r_rep_cnt;
  logic        r_rep_armed;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cand  <= KEY_NONE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_value <= '0;
      r_busy  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
`endif
    end else if (!i_enable) begin
      // key_value deliberately survives a scan pause
      r_state <= IDLE;
      r_cand  <= KEY_NONE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (i_frame_end) begin
        case (r_state)
          IDLE: begin
            if (i_frame_code != KEY_NONE) begin
              r_cand <= i_frame_code;
              r_busy <= 1'b1;
              if (DEB == 16'd1) begin
                r_valid <= 1'b1;
                r_value <= i_frame_code;
                r_cnt   <= '0;
                r_state <= HELD;
`ifdef KEYPAD_REPEAT_EN
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
`endif
              end else begin
                r_cnt   <= 16'd1;
                r_state <= PRESS_WAIT;
              end
            end
          end
          PRESS_WAIT: begin
            if (i_frame_code == KEY_NONE) begin
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else if (i_frame_code == r_cand) begin
              if (r_cnt + 16'd1 >= DEB) begin
                r_valid <= 1'b1;
                r_value <= r_cand;
                r_cnt   <= '0;
                r_state <= HELD;
`ifdef KEYPAD_REPEAT_EN
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
`endif
              end else begin
                r_cnt <= r_cnt + 16'd1;
              end
            end else begin
              r_cand <= i_frame_code;
              r_cnt  <= 16'd1;
            end
          end
          HELD: begin
            if (i_frame_code == KEY_NONE) begin
`ifdef KEYPAD_REPEAT_EN
              r_rep_cnt   <= '0;
              r_rep_armed <= 1'b0;
`endif
              if (DEB == 16'd1) begin
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end else begin
                r_cnt   <= 16'd1;
                r_state <= RELEASE_WAIT;
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if ((!r_rep_armed && (r_rep_cnt + 16'd1 == RDLY)) ||
                     (r_rep_armed && (r_rep_cnt + 16'd1 == RPER))) begin
              r_valid     <= 1'b1;
              r_rep_cnt   <= '0;
              r_rep_armed <= 1'b1;
            end else begin
              r_rep_cnt <= r_rep_cnt + 16'd1;
            end
`endif
          end
          RELEASE_WAIT: begin
            if (i_frame_code != KEY_NONE) begin
              r_cnt   <= '0;
              r_state <= HELD;
            end else if (r_cnt + 16'd1 >= DEB) begin
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_key_valid = r_valid;
  assign o_key_value = r_value;
  assign o_key_busy  = r_busy;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 3x4 keypad column scanner, row synchroniser and frame decoder feeding the debouncer.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_value,
  output logic       key_busy
);

  localparam int DW = $clog2(SCAN_DIV);

  if (SCAN_DIV < 2) begin : g_bad_div
    $error("keypad_matrix_scanner: SCAN_DIV must be at least 2");
  end

  logic [DW-1:0] r_div;
  logic [1:0]    r_col_idx;
  logic          r_scan_on;
  logic [3:0]    r_row_s1;
  logic [3:0]    r_row_s2;
  logic [3:0]    r_hit_c0;
  logic [3:0]    r_hit_c1;
  logic          r_frame_end;
  logic [3:0]    r_frame_code;
  logic          w_sample;
  logic [11:0]   w_hits;
  logic [3:0]    w_nhits;
  logic [3:0]    w_found;
  logic [3:0]    w_code;

  assign w_sample = r_scan_on && (r_div == DW'(SCAN_DIV - 1));
  assign w_hits   = {~r_row_s2, r_hit_c1, r_hit_c0};

  // Columns 0/1 are latched earlier in the frame; column 2 is decoded live at frame end.
  always_comb begin
    w_nhits = '0;
    w_found = KEY_NONE;
    for (int unsigned c = 0; c < 3; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (w_hits[c*4 + r]) begin
          w_nhits = w_nhits + 4'd1;
          w_found = key_code(2'(r), 2'(c));
        end
      end
    end
    w_code = (w_nhits == 4'd1) ? w_found : KEY_NONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_s1     <= '1;
      r_row_s2     <= '1;
      r_div        <= '0;
      r_col_idx    <= '0;
      r_scan_on    <= 1'b1;
      r_hit_c0     <= '0;
      r_hit_c1     <= '0;
      r_frame_end  <= 1'b0;
      r_frame_code <= KEY_NONE;
    end else begin
      r_row_s1    <= key_row;
      r_row_s2    <= r_row_s1;
      r_frame_end <= 1'b0;
      r_scan_on   <= scan_en;
      if (!scan_en) begin
        // parked at col 0 so re-enable starts a clean frame
        r_div     <= '0;
        r_col_idx <= '0;
        r_hit_c0  <= '0;
        r_hit_c1  <= '0;
      end else if (r_scan_on) begin
        if (w_sample) begin
          r_div <= '0;
          case (r_col_idx)
            2'd0: begin
              r_hit_c0  <= ~r_row_s2;
              r_col_idx <= 2'd1;
            end
            2'd1: begin
              r_hit_c1  <= ~r_row_s2;
              r_col_idx <= 2'd2;
            end
            default: begin
              r_col_idx    <= 2'd0;
              r_frame_end  <= 1'b1;
              r_frame_code <= w_code;
            end
          endcase
        end else begin
          r_div <= r_div + DW'(1);
        end
      end
    end
  end

  always_comb begin
    key_col = 3'b111;
    if (r_scan_on) begin
      case (r_col_idx)
        2'd0:    key_col = 3'b110;
        2'd1:    key_col = 3'b101;
        default: key_col = 3'b011;
      endcase
    end
  end

  keypad_debounce_fsm #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_debounce (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (scan_en),
    .i_frame_end  (r_frame_end),
    .i_frame_code (r_frame_code),
    .o_key_valid  (key_valid),
    .o_key_value  (key_value),
    .o_key_busy   (key_busy)
  );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural keypad matrix (SCAN_DIV=4, 3 frames debounce).
module tb_keypad_matrix_scanner;

  localparam int FRAME = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_en = 1'b1;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       key_valid;
  logic [3:0] key_value;
  logic       key_busy;
  logic [11:0] pressed = '0;  // bit index = row*3 + col

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3 + c] && !key_col[c]) key_row[r] = 1'b0;
  end

  keypad_matrix_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3),
`ifdef KEYPAD_REPEAT_EN
    .REPEAT_DELAY    (5),
    .REPEAT_PERIOD   (2)
`else
    .REPEAT_DELAY    (50),
    .REPEAT_PERIOD   (10)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_valid (key_valid),
    .key_value (key_value),
    .key_busy  (key_busy)
  );

  longint     cyc = 0;
  int         n_pulse = 0;
  int         n_consec = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] pulse_vals[$];
  longint     pulse_cycs[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (key_valid) begin
      n_pulse++;
      pulse_vals.push_back(key_value);
      pulse_cycs.push_back(cyc);
      if (prev_valid) n_consec++;
    end
    prev_valid = key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(7);
    rst_n = 1'b0;
    step(5);
    n_vec++; if (key_col !== 3'b110) begin n_err++; $display("FAIL reset_col: got %b expected 110", key_col); end
    n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    n_vec++; if (key_value !== 4'd0) begin n_err++; $display("FAIL reset_value: got %0d expected 0", key_value); end
    n_vec++; if (key_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", key_busy); end
    rst_n = 1'b1;
    step(3);
    n_vec++; if (key_col !== 3'b110) begin n_err++; $display("FAIL col0_window: got %b expected 110", key_col); end
    step(1);
    n_vec++; if (key_col !== 3'b101) begin n_err++; $display("FAIL col1_window: got %b expected 101", key_col); end
  endtask

  task automatic test_single_key;
    int base;
    int k;
    base = n_pulse;
    pressed = '0;
    pressed[4] = 1'b1;
    k = 0;
    while (n_pulse == base && k < 60) begin step(1); k++; end
    n_vec++; if (k > 50) begin n_err++; $display("FAIL key5_latency: got %0d cycles expected <= 50", k); end
    step(10*FRAME - k);
    pressed = '0;
    n_vec++; if (n_pulse - base !== 1) begin n_err++; $display("FAIL key5_pulses: got %0d expected 1", n_pulse - base); end
    n_vec++; if (key_value !== 4'd5) begin n_err++; $display("FAIL key5_value: got %0d expected 5", key_value); end
    step(20);
    n_vec++; if (key_busy !== 1'b1) begin n_err++; $display("FAIL key5_busy_release_wait: got %b expected 1", key_busy); end
    step(28);
    n_vec++; if (key_busy !== 1'b0) begin n_err++; $display("FAIL key5_busy_idle: got %b expected 0", key_busy); end
    n_vec++; if (n_pulse - base !== 1) begin n_err++; $display("FAIL key5_no_release_pulse: got %0d expected 1", n_pulse - base); end
  endtask

  task automatic test_sequence;
    int base;
    int bits[3];
    logic [3:0] expv[3];
    bits = '{9, 11, 10};
    expv = '{4'd10, 4'd11, 4'd0};
    base = n_pulse;
    for (int i = 0; i < 3; i++) begin
      pressed = '0;
      pressed[bits[i]] = 1'b1;
      step(5*FRAME);
      pressed = '0;
      step(5*FRAME);
    end
    n_vec++; if (n_pulse - base !== 3) begin n_err++; $display("FAIL seq_pulses: got %0d expected 3", n_pulse - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < pulse_vals.size()) begin
        n_vec++;
        if (pulse_vals[base + i] !== expv[i]) begin
          n_err++; $display("FAIL seq_value%0d: got %0d expected %0d", i, pulse_vals[base + i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_bounce;
    int base;
    base = n_pulse;
    for (int i = 0; i < 6; i++) begin
      pressed = '0;
      pressed[2] = (i % 2 == 0);
      step(FRAME);
    end
    pressed = '0;
    step(5*FRAME);
    n_vec++; if (n_pulse !== base) begin n_err++; $display("FAIL bounce_pulses: got %0d expected 0", n_pulse - base); end
    n_vec++; if (key_busy !== 1'b0) begin n_err++; $display("FAIL bounce_busy: got %b expected 0", key_busy); end
  endtask

  task automatic test_multi_press;
    int base;
    base = n_pulse;
    pressed = 12'b0000_0000_0011;
    step(5*FRAME);
    n_vec++; if (n_pulse !== base) begin n_err++; $display("FAIL multi_overlap_pulses: got %0d expected 0", n_pulse - base); end
    n_vec++; if (key_busy !== 1'b0) begin n_err++; $display("FAIL multi_overlap_busy: got %b expected 0", key_busy); end
    pressed[1] = 1'b0;
    step(6*FRAME);
    n_vec++; if (n_pulse - base !== 1) begin n_err++; $display("FAIL multi_single_pulses: got %0d expected 1", n_pulse - base); end
    n_vec++; if (key_value !== 4'd1) begin n_err++; $display("FAIL multi_value: got %0d expected 1", key_value); end
    pressed = '0;
    step(5*FRAME);
  endtask

  task automatic test_scan_enable;
    int base;
    int k;
    base = n_pulse;
    pressed = '0;
    pressed[7] = 1'b1;
    k = 0;
    while (key_busy !== 1'b1 && k < 40) begin step(1); k++; end
    n_vec++; if (key_busy !== 1'b1) begin n_err++; $display("FAIL scan_press_wait: got busy %b expected 1", key_busy); end
    step(2);
    scan_en = 1'b0;
    step(1);
    n_vec++; if (key_col !== 3'b111) begin n_err++; $display("FAIL scan_off_col: got %b expected 111", key_col); end
    n_vec++; if (key_busy !== 1'b0) begin n_err++; $display("FAIL scan_off_busy: got %b expected 0", key_busy); end
    n_vec++; if (key_value !== 4'd1) begin n_err++; $display("FAIL scan_off_value_hold: got %0d expected 1", key_value); end
    step(3*FRAME);
    n_vec++; if (n_pulse !== base) begin n_err++; $display("FAIL scan_off_pulses: got %0d expected 0", n_pulse - base); end
    n_vec++; if (key_col !== 3'b111) begin n_err++; $display("FAIL scan_off_col_later: got %b expected 111", key_col); end
    scan_en = 1'b1;
    k = 0;
    while (n_pulse == base && k < 80) begin step(1); k++; end
    n_vec++; if (n_pulse == base || k < 30) begin n_err++; $display("FAIL scan_resume_latency: got %0d cycles (pulses %0d) expected 30..79 and 1 pulse", k, n_pulse - base); end
    step(2*FRAME);
    n_vec++; if (n_pulse - base !== 1) begin n_err++; $display("FAIL scan_resume_pulses: got %0d expected 1", n_pulse - base); end
    n_vec++; if (key_value !== 4'd8) begin n_err++; $display("FAIL scan_resume_value: got %0d expected 8", key_value); end
    pressed = '0;
    step(5*FRAME);
  endtask

  task automatic test_reset_midop;
    int base;
    int k;
    base = n_pulse;
    pressed = '0;
    pressed[8] = 1'b1;
    k = 0;
    while (key_busy !== 1'b1 && k < 40) begin step(1); k++; end
    step(16);
    rst_n = 1'b0;
    pressed = '0;
    step(5);
    n_vec++; if (key_col !== 3'b110) begin n_err++; $display("FAIL midrst_col: got %b expected 110", key_col); end
    n_vec++; if (key_value !== 4'd0) begin n_err++; $display("FAIL midrst_value: got %0d expected 0", key_value); end
    n_vec++; if (key_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", key_busy); end
    rst_n = 1'b1;
    step(5*FRAME);
    n_vec++; if (n_pulse !== base) begin n_err++; $display("FAIL midrst_pending_pulse: got %0d expected 0", n_pulse - base); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat;
    int base;
    base = n_pulse;
    pressed = '0;
    pressed[6] = 1'b1;
    step(12*FRAME);
    pressed = '0;
    step(5*FRAME);
    n_vec++; if (n_pulse - base < 3) begin n_err++; $display("FAIL repeat_count: got %0d expected >= 3", n_pulse - base); end
    if (n_pulse - base >= 3) begin
      n_vec++; if (pulse_cycs[base+1] - pulse_cycs[base] !== 60) begin n_err++; $display("FAIL repeat_delay: got %0d cycles expected 60", pulse_cycs[base+1] - pulse_cycs[base]); end
      n_vec++; if (pulse_cycs[base+2] - pulse_cycs[base+1] !== 24) begin n_err++; $display("FAIL repeat_period: got %0d cycles expected 24", pulse_cycs[base+2] - pulse_cycs[base+1]); end
      for (int i = base; i < n_pulse; i++) begin
        n_vec++; if (pulse_vals[i] !== 4'd7) begin n_err++; $display("FAIL repeat_value: got %0d expected 7", pulse_vals[i]); end
      end
    end
  endtask
`endif

  task automatic test_pulse_width;
    n_vec++; if (n_consec !== 0) begin n_err++; $display("FAIL valid_back_to_back: got %0d expected 0", n_consec); end
  endtask

  initial begin
    test_reset;
    test_single_key;
    test_sequence;
    test_bounce;
    test_multi_press;
    test_scan_enable;
    test_reset_midop;
`ifdef KEYPAD_REPEAT_EN
    test_repeat;
`endif
    test_pulse_width;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before 500000");
    $fatal(1, "watchdog");
  end

endmodule
